// File: rtl/store_commit_buffer_if.sv
// Bundle of the load/store-unit push port, commit/flush controls, cache drain port
// and hazard-query signals of the store commit buffer.
interface store_commit_buffer_if #(
    parameter int ADDR_W = 56,
    parameter int DATA_W = 64,
    parameter int BE_W   = 8
);
    logic              flush_i;
    logic              spec_valid_i;
    logic              spec_ready_o;
    logic [ADDR_W-1:0] spec_addr_i;
    logic [DATA_W-1:0] spec_data_i;
    logic [BE_W-1:0]   spec_be_i;
    logic              commit_i;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [11:0]       page_off_i;
    logic              page_off_match_o;
    logic              empty_o;
    logic              no_spec_o;

    modport slave (
        input  flush_i, spec_valid_i, spec_addr_i, spec_data_i, spec_be_i,
        input  commit_i, mem_gnt_i, page_off_i,
        output spec_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
        output page_off_match_o, empty_o, no_spec_o
    );

    modport master (
        output flush_i, spec_valid_i, spec_addr_i, spec_data_i, spec_be_i,
        output commit_i, mem_gnt_i, page_off_i,
        input  spec_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
        input  page_off_match_o, empty_o, no_spec_o
    );
endinterface

// File: rtl/store_commit_buffer.sv
// Circular store buffer: speculative stores wait for commit, committed stores drain
// in order to the cache; speculative tail is dropped on flush.
module store_commit_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 56,
    parameter int DATA_W = 64,
    parameter int BE_W   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    store_commit_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [BE_W-1:0]   r_be   [DEPTH];

    logic [PTR_W-1:0]  r_rd_ptr, r_cm_ptr, r_wr_ptr;
    logic [CNT_W-1:0]  r_com_cnt, r_spec_cnt;

    logic [CNT_W-1:0]  w_total;
    logic              w_push, w_commit, w_pop;
    logic [PTR_W-1:0]  w_cm_ptr_next;
    logic [DEPTH-1:0]  w_hit;
    logic              w_unused;

    // Occupancy comes from registered counts only, so a same-cycle drain never frees space.
    assign w_total          = r_com_cnt + r_spec_cnt;
    assign bus.spec_ready_o = (w_total < CNT_W'(DEPTH));
    assign bus.empty_o      = (r_com_cnt == '0) && (r_spec_cnt == '0);
    assign bus.no_spec_o    = (r_spec_cnt == '0);

    assign w_push        = bus.spec_valid_i & bus.spec_ready_o & ~bus.flush_i;
    assign w_commit      = bus.commit_i & (r_spec_cnt != '0);
    assign w_cm_ptr_next = r_cm_ptr + PTR_W'(w_commit);

    assign bus.mem_req_o  = (r_com_cnt != '0);
    assign w_pop          = bus.mem_req_o & bus.mem_gnt_i;
    assign bus.mem_addr_o = r_addr[r_rd_ptr];
    assign bus.mem_data_o = r_data[r_rd_ptr];
    assign bus.mem_be_o   = r_be[r_rd_ptr];

    // A slot is live when its distance from the oldest entry is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        logic [PTR_W-1:0] w_off;
        assign w_off     = PTR_W'(gi) - r_rd_ptr;
        assign w_hit[gi] = ({1'b0, w_off} < w_total) &&
                           (r_addr[gi][11:3] == bus.page_off_i[11:3]);
    end

    assign bus.page_off_match_o = |w_hit;
    assign w_unused             = &{1'b0, bus.page_off_i[2:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
            r_rd_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_com_cnt  <= '0;
            r_spec_cnt <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr] <= bus.spec_addr_i;
                r_data[r_wr_ptr] <= bus.spec_data_i;
                r_be[r_wr_ptr]   <= bus.spec_be_i;
            end
            r_rd_ptr  <= r_rd_ptr + PTR_W'(w_pop);
            r_cm_ptr  <= w_cm_ptr_next;
            r_com_cnt <= r_com_cnt + CNT_W'(w_commit) - CNT_W'(w_pop);
            // Flush keeps this cycle's commit, then rewinds the write pointer over the speculative tail.
            if (bus.flush_i) begin
                r_wr_ptr   <= w_cm_ptr_next;
                r_spec_cnt <= '0;
            end else begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
                r_spec_cnt <= r_spec_cnt + CNT_W'(w_push) - CNT_W'(w_commit);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.commit_i) begin
            assert (r_spec_cnt != '0);
        end
    end
endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomized scoreboard bench for store_commit_buffer with a queue-based reference model.
module tb_store_commit_buffer;
    localparam int DEPTH = 8;

    typedef struct {
        logic [55:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ent_t spec_q[$];
    ent_t com_q[$];
    ent_t exp_q[$];

    always #5 clk = ~clk;

    store_commit_buffer_if #(.ADDR_W(56), .DATA_W(64), .BE_W(8)) bus ();

    store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(56), .DATA_W(64), .BE_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", n, act, exp);
        end
    endtask

    function automatic logic model_match(input logic [11:0] po);
        logic m = 1'b0;
        foreach (spec_q[i]) if (spec_q[i].a[11:3] == po[11:3]) m = 1'b1;
        foreach (com_q[i])  if (com_q[i].a[11:3] == po[11:3]) m = 1'b1;
        return m;
    endfunction

    task automatic check_status(input logic [11:0] po);
        int tot = spec_q.size() + com_q.size();
        chk("spec_ready", bus.spec_ready_o, 64'(tot < DEPTH));
        chk("mem_req",    bus.mem_req_o,    64'(com_q.size() > 0));
        chk("empty",      bus.empty_o,      64'(tot == 0));
        chk("no_spec",    bus.no_spec_o,    64'(spec_q.size() == 0));
        chk("match",      bus.page_off_match_o, 64'(model_match(po)));
        if (com_q.size() > 0) begin
            chk("head_addr", 64'(bus.mem_addr_o), 64'(com_q[0].a));
            chk("head_data", bus.mem_data_o,      com_q[0].d);
            chk("head_be",   64'(bus.mem_be_o),   64'(com_q[0].be));
        end
    endtask

    // One clock cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step(input logic v, input logic [55:0] a, input logic [63:0] d,
                        input logic [7:0] be, input logic cm, input logic fl,
                        input logic g, input logic [11:0] po);
        ent_t e;
        bit   acc;
        bus.spec_valid_i = v;
        bus.spec_addr_i  = a;
        bus.spec_data_i  = d;
        bus.spec_be_i    = be;
        bus.commit_i     = cm;
        bus.flush_i      = fl;
        bus.mem_gnt_i    = g;
        bus.page_off_i   = po;
        @(negedge clk);
        check_status(po);
        acc = v && (spec_q.size() + com_q.size() < DEPTH) && !fl;
        if (g && com_q.size() > 0) void'(com_q.pop_front());
        if (cm && spec_q.size() > 0) begin
            e = spec_q.pop_front();
            com_q.push_back(e);
            exp_q.push_back(e);
        end
        if (fl) spec_q.delete();
        if (acc) begin
            e.a = a; e.d = d; e.be = be;
            spec_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic g, input logic [11:0] po);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, g, po);
    endtask

    // Monitor: every accepted drain beat is compared with the oldest committed store.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.mem_req_o === 1'b1 && bus.mem_gnt_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=drain required=none addr=0x%0h", bus.mem_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    $display("drain addr=0x%0h data=0x%0h be=0x%0h", bus.mem_addr_o, bus.mem_data_o, bus.mem_be_o);
                    chk("sb_addr", 64'(bus.mem_addr_o), 64'(e.a));
                    chk("sb_data", bus.mem_data_o, e.d);
                    chk("sb_be",   64'(bus.mem_be_o), 64'(e.be));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [55:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        logic        v, cm, fl, g;
        logic [11:0] po;
        int          n;

        bus.spec_valid_i = 0; bus.spec_addr_i = '0; bus.spec_data_i = '0; bus.spec_be_i = '0;
        bus.commit_i = 0; bus.flush_i = 0; bus.mem_gnt_i = 0; bus.page_off_i = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.spec_ready_o, 1);
        chk("rst_req",   bus.mem_req_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_nospec", bus.no_spec_o, 1);
        chk("rst_match", bus.page_off_match_o, 0);
        chk("rst_addr",  64'(bus.mem_addr_o), 0);
        chk("rst_data",  bus.mem_data_o, 0);
        chk("rst_be",    64'(bus.mem_be_o), 0);
        @(posedge clk);
        #1;

        // Minimum latency push -> commit -> request.
        step(1, 56'h8000_0010, 64'h11, 8'hFF, 0, 0, 1, '0);
        step(0, '0, '0, '0, 1, 0, 1, '0);
        idle(1, '0);
        idle(1, '0);

        // Fill past capacity, then commit and drain across the pointer wrap.
        for (int i = 0; i < 9; i++)
            step(1, 56'h1000 + 56'(i * 8), 64'hA0 + 64'(i), 8'(1 << (i % 8)), 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) step(0, '0, '0, '0, 1, 0, 1, '0);
        repeat (3) idle(1, '0);

        // Flush together with a commit: two committed survive.
        for (int i = 0; i < 3; i++) step(1, 56'h2000 + 56'(i * 8), 64'hB0 + 64'(i), 8'h0F, 0, 0, 0, '0);
        step(0, '0, '0, '0, 1, 0, 0, '0);
        step(1, 56'h2F00, 64'hDEAD, 8'hFF, 1, 1, 0, '0);
        step(1, 56'h2100, 64'hC0, 8'hF0, 0, 0, 1, '0);
        step(0, '0, '0, '0, 1, 0, 1, '0);
        repeat (3) idle(1, '0);

        // Stall the drain, then push + commit + grant in one cycle.
        step(1, 56'h3000, 64'hC1, 8'h33, 0, 0, 0, '0);
        step(1, 56'h3008, 64'hC2, 8'h44, 1, 0, 0, '0);
        repeat (5) idle(0, '0);
        step(1, 56'h3010, 64'hC3, 8'h55, 1, 0, 1, '0);
        step(0, '0, '0, '0, 1, 0, 1, '0);
        repeat (3) idle(1, '0);

        // Page-offset hazard query.
        step(1, 56'h8000_1238, 64'hE0, 8'hFF, 0, 0, 0, 12'h23C);
        idle(0, 12'h23C);
        chk("match_hit", bus.page_off_match_o, 1);
        idle(0, 12'h240);
        chk("match_miss", bus.page_off_match_o, 0);
        step(0, '0, '0, '0, 0, 1, 0, 12'h23C);
        idle(0, 12'h23C);
        chk("match_flushed", bus.page_off_match_o, 0);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            a        = {$urandom(), $urandom()} >> 8;
            a[11:3]  = 9'($urandom_range(9'h40, 9'h47));
            d        = {$urandom(), $urandom()};
            be       = 8'($urandom());
            v        = ($urandom_range(0, 99) < 60);
            cm       = (spec_q.size() > 0) && ($urandom_range(0, 99) < 45);
            fl       = ($urandom_range(0, 99) < 4);
            g        = ($urandom_range(0, 99) < 60);
            po       = {9'($urandom_range(9'h40, 9'h48)), 3'($urandom())};
            step(v, a, d, be, cm, fl, g, po);
        end

        // Commit everything left and drain it out.
        n = 0;
        while ((spec_q.size() + com_q.size() > 0) && n < 40) begin
            step(0, '0, '0, '0, (spec_q.size() > 0), 0, 1, '0);
            n++;
        end
        idle(1, '0);
        chk("sb_drained", 64'(exp_q.size()), 0);
        chk("model_empty", 64'(spec_q.size() + com_q.size()), 0);

        // Reset in the middle of activity discards committed entries too.
        step(1, 56'h4000, 64'hF1, 8'hFF, 0, 0, 0, '0);
        step(1, 56'h4008, 64'hF2, 8'hFF, 1, 0, 0, '0);
        bus.spec_valid_i = 0; bus.commit_i = 0; bus.flush_i = 0; bus.mem_gnt_i = 0;
        rst = 1'b1;
        @(negedge clk);
        spec_q.delete(); com_q.delete(); exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_req",   bus.mem_req_o, 0);
        chk("mrst_empty", bus.empty_o, 1);
        chk("mrst_addr",  64'(bus.mem_addr_o), 0);
        @(posedge clk);
        #1;
        idle(1, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
